// File: rtl/cache_controller.sv
// cache_controller
//   2-way set-associative read cache sitting between the memory stage and an
//   SRAM controller. Loads hit with zero latency; misses fetch a 64-bit line.
//   Stores are write-through / no-allocate and invalidate a hitting line.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   address, wdata           request address / store data
//   MEM_R_EN, MEM_W_EN       load / store request (both set => store)
//   rdata, ready             load data, request complete (pipeline freezes on 0)
//   sram_address, sram_wdata pass-through of address / wdata
//   sram_read, sram_write    SRAM line read / word write request
//   sram_rdata, sram_ready   SRAM line data, SRAM operation done
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    state_t              state_q;
    logic [SETS-1:0]     valid0_q, valid1_q, lru_q;
    logic [TAG_W-1:0]    tag0_q  [SETS];
    logic [TAG_W-1:0]    tag1_q  [SETS];
    logic [63:0]         data0_q [SETS];
    logic [63:0]         data1_q [SETS];

    logic                word_sel;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                hit_way0, hit_way1, hit;
    logic                victim;
    logic                fill;
    logic                unused_addr;

    assign word_sel    = address[2];
    assign idx         = address[INDEX_W+2:3];
    assign tag         = address[TAG_W+INDEX_W+2:INDEX_W+3];
    assign unused_addr = ^{address[31:TAG_W+INDEX_W+3], address[1:0]};

    assign hit_way0 = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit_way1 = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit      = hit_way0 || hit_way1;

    // Prefer an empty way (way 0 first); otherwise evict the LRU way.
    assign victim = !valid0_q[idx] ? 1'b0 :
                    !valid1_q[idx] ? 1'b1 : lru_q[idx];

    assign fill = (state_q == READ_MISS) && sram_ready;

    assign sram_address = address;
    assign sram_wdata   = wdata;

    always_comb begin
        ready      = 1'b1;
        rdata      = '0;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready = 1'b0;
                end else if (MEM_R_EN) begin
                    if (hit_way0)
                        rdata = word_sel ? data0_q[idx][63:32] : data0_q[idx][31:0];
                    else if (hit_way1)
                        rdata = word_sel ? data1_q[idx][63:32] : data1_q[idx][31:0];
                    else
                        ready = 1'b0;
                end
            end
            READ_MISS: begin
                sram_read = 1'b1;
                ready     = sram_ready;
                if (sram_ready)
                    rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
            end
            WRITE: begin
                sram_write = 1'b1;
                ready      = sram_ready;
            end
            default: ;
        endcase
    end

    // Control state: FSM, valid and LRU bits. LRU bit names the least-recent way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MEM_W_EN)
                        state_q <= WRITE;
                    else if (MEM_R_EN) begin
                        if (hit)
                            lru_q[idx] <= hit_way0;
                        else
                            state_q <= READ_MISS;
                    end
                end
                READ_MISS: begin
                    if (sram_ready) begin
                        if (victim) valid1_q[idx] <= 1'b1;
                        else        valid0_q[idx] <= 1'b1;
                        lru_q[idx] <= ~victim;
                        state_q    <= IDLE;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (hit_way0) valid0_q[idx] <= 1'b0;
                        if (hit_way1) valid1_q[idx] <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; a reset edge still blocks the fill.
    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            if (victim) begin
                tag1_q[idx]  <= tag;
                data1_q[idx] <= sram_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                data0_q[idx] <= sram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address, sram_wdata;
    logic        sram_read, sram_write;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_read(sram_read), .sram_write(sram_write),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0; sram_rdata = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_sram_rw", {sram_read, sram_write}, 0);
        check("rst_rdata", rdata, 0);
    endtask

    // Load. For a hit, line is what the cache must hold; for a miss, what SRAM returns.
    task automatic do_read(input string tag, input logic [31:0] a, input bit exp_hit,
                           input logic [63:0] line, input int lat);
        logic [31:0] exp;
        @(posedge clk); #1;
        address = a; MEM_R_EN = 1'b1;
        exp_q.push_back(a[2] ? line[63:32] : line[31:0]);
        @(negedge clk);
        check({tag, "_addr"}, sram_address, a);
        check({tag, "_sram_rd0"}, sram_read, 0);
        if (exp_hit) begin
            check({tag, "_hit_ready"}, ready, 1);
            exp = exp_q.pop_front();
            check({tag, "_hit_rdata"}, rdata, exp);
        end else begin
            check({tag, "_miss_ready"}, ready, 0);
            for (int i = 0; i < lat; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check({tag, "_wait_sram_rd"}, sram_read, 1);
                check({tag, "_wait_ready"}, ready, 0);
            end
            @(posedge clk); #1;
            sram_ready = 1'b1; sram_rdata = line;
            @(negedge clk);
            check({tag, "_fill_ready"}, ready, 1);
            check({tag, "_fill_sram_rd"}, sram_read, 1);
            exp = exp_q.pop_front();
            check({tag, "_fill_rdata"}, rdata, exp);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({tag, "_back_idle"}, {ready, sram_read, sram_write}, 3'b100);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input bit also_read, input int lat);
        @(posedge clk); #1;
        address = a; wdata = d; MEM_W_EN = 1'b1; MEM_R_EN = also_read;
        @(negedge clk);
        check({tag, "_req_ready"}, ready, 0);
        check({tag, "_req_sram_rw"}, {sram_read, sram_write}, 0);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_wait_rw"}, {sram_read, sram_write}, 2'b01);
            check({tag, "_wait_wdata"}, sram_wdata, d);
            check({tag, "_wait_ready"}, ready, 0);
        end
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_ready"}, ready, 1);
        check({tag, "_done_rw"}, {sram_read, sram_write}, 2'b01);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    localparam logic [63:0] L4  = 64'hBBBB_BBBB_AAAA_AAAA;
    localparam logic [63:0] L6  = 64'h6666_6661_6666_6660;
    localparam logic [63:0] L8  = 64'h8888_8881_8888_8880;
    localparam logic [63:0] L4B = 64'h4444_4441_4444_4440;
    localparam logic [63:0] LA  = 64'hAAAA_0001_AAAA_0000;

    initial begin
        rst = 1'b0; address = '0; wdata = '0;
        idle_inputs();
        apply_reset();

        // Miss to word 1, then zero-latency hit to word 0 of the same line.
        do_read("r404_miss", 32'h0000_0404, 1'b0, L4, 2);
        do_read("r400_hit",  32'h0000_0400, 1'b1, L4, 0);

        // LRU eviction within set 0.
        apply_reset();
        do_read("e400_miss", 32'h0000_0400, 1'b0, L4, 1);
        do_read("e600_miss", 32'h0000_0600, 1'b0, L6, 1);
        do_read("e800_miss", 32'h0000_0800, 1'b0, L8, 3);
        do_read("e804_hit",  32'h0000_0804, 1'b1, L8, 0);
        do_read("e600_hit",  32'h0000_0600, 1'b1, L6, 0);
        do_read("e400_miss2", 32'h0000_0400, 1'b0, L4B, 1);
        do_read("e604_hit",  32'h0000_0604, 1'b1, L6, 0);

        // Write-through to a cached line invalidates it.
        do_write("w400", 32'h0000_0400, 32'h1234_5678, 1'b0, 2);
        do_read("w400_rmiss", 32'h0000_0400, 1'b0, L4, 1);
        do_read("w604_still", 32'h0000_0604, 1'b1, L6, 0);

        // Reset in the middle of a read miss abandons the fill.
        @(posedge clk); #1;
        address = 32'h0000_1008; MEM_R_EN = 1'b1;
        @(negedge clk);
        check("abort_req_ready", ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_in_miss", sram_read, 1);
        rst = 1'b1; sram_rdata = LA;
        @(posedge clk); #1;
        rst = 1'b0; idle_inputs();
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_sram_rd", sram_read, 0);
        do_read("abort_rmiss", 32'h0000_1008, 1'b0, LA, 1);
        do_read("abort_rhit",  32'h0000_100C, 1'b1, LA, 0);

        // Both enables: store path, and the hit line gets invalidated.
        do_write("both", 32'h0000_1008, 32'hCAFE_F00D, 1'b1, 1);
        do_read("both_rmiss", 32'h0000_1008, 1'b0, LA, 1);

        // Idle with a stale address: rdata must be zero.
        @(posedge clk); #1;
        address = 32'h0000_1008;
        @(negedge clk);
        check("idle_rdata", rdata, 0);
        check("idle_ready", ready, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, set-index width (64 sets).
REQ-002 SHALL have parameter TAG_W, default 10, tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port address, input, 32, byte address from the memory stage; bit [2] = word select, [INDEX_W+2:3] = index, [TAG_W+INDEX_W+2:INDEX_W+3] = tag; other bits ignored.
REQ-006 SHALL have port wdata, input, 32, store data.
REQ-007 SHALL have port MEM_R_EN, input, 1, load request.
REQ-008 SHALL have port MEM_W_EN, input, 1, store request.
REQ-009 SHALL have port rdata, output, 32, load data.
REQ-010 SHALL have port ready, output, 1, request complete; the pipeline freezes while it is 0.
REQ-011 SHALL have port sram_address, output, 32, address to the SRAM controller; equals address.
REQ-012 SHALL have port sram_wdata, output, 32, store data to SRAM; equals wdata.
REQ-013 SHALL have port sram_read, output, 1, SRAM 64-bit line read request.
REQ-014 SHALL have port sram_write, output, 1, SRAM 32-bit word write request.
REQ-015 SHALL have port sram_rdata, input, 64, line from SRAM; [31:0] = word 0, [63:32] = word 1.
REQ-016 SHALL have port sram_ready, input, 1, SRAM operation done; sampled only while sram_read or sram_write is 1.

Function
REQ-017 SHALL be organised as 2-way set-associative, 2^INDEX_W sets, 64-bit lines (two words); per way: valid, tag, 64-bit data; one LRU bit per set (LRU=0 means way 0 is least recent).
REQ-018 SHALL compute hit combinationally: hit_wayN = validN && tagN == address tag for the indexed set; hit = hit_way0 || hit_way1.
REQ-019 SHALL implement FSM states IDLE, READ_MISS, WRITE.
REQ-020 IDLE with no request: SHALL drive ready=1, sram_read=0, sram_write=0, rdata=0.
REQ-021 IDLE, MEM_R_EN=1, hit: SHALL drive ready=1 and rdata = the hit way's selected word in the same cycle (zero latency); at the clock edge SHALL set LRU to the non-hit way and stay in IDLE.
REQ-022 IDLE, MEM_R_EN=1, miss: SHALL drive ready=0 and go to READ_MISS.
REQ-023 READ_MISS: SHALL hold sram_read=1 and ready=0 until sram_ready=1.
REQ-024 READ_MISS with sram_ready=1: SHALL drive ready=1 and rdata = the selected word of sram_rdata that cycle; at the edge SHALL fill the victim way (data, tag, valid=1), set LRU to the other way, and return to IDLE.
REQ-025 Victim selection: SHALL choose an invalid way if one exists (way 0 if both are invalid); otherwise the way indicated by LRU.
REQ-026 IDLE, MEM_W_EN=1: SHALL drive ready=0 and go to WRITE; write-through, no-allocate.
REQ-027 WRITE: SHALL hold sram_write=1 and ready=0 until sram_ready=1; on sram_ready it SHALL drive ready=1 that cycle and return to IDLE.
REQ-028 On a write that hits, SHALL clear the hit way's valid bit at the edge where sram_ready=1; LRU unchanged.
REQ-029 MEM_R_EN and MEM_W_EN both 1: SHALL be treated as a write.
REQ-030 Requester holds address, wdata and enables stable while ready=0; the block SHALL NOT re-sample a new request until it returns to IDLE.
REQ-031 sram_read and sram_write SHALL never be 1 simultaneously, and SHALL never be 1 in IDLE.
REQ-032 Request deasserted mid-miss (illegal): the outstanding SRAM operation SHALL still complete before returning to IDLE.

Reset
REQ-033 rst=1 at a clock edge SHALL clear all valid and LRU bits and force state to IDLE; sram_read=0, sram_write=0, ready=1 the following cycle.
REQ-034 rst asserted in READ_MISS or WRITE SHALL abandon the operation with no line fill and no valid-bit change other than the clear.
REQ-035 Tag and data arrays need not be reset.

Verification
REQ-036 After reset, read addr 0x0000_0404 -> ready=0, sram_read=1 until sram_ready; return sram_rdata=0xBBBB_BBBB_AAAA_AAAA -> rdata=0xBBBB_BBBB (word 1), ready=1 that cycle, way 0 filled.
REQ-037 Re-read 0x0000_0400 -> same-cycle hit, ready=1, rdata=0xAAAA_AAAA, no sram_read.
REQ-038 Read misses to 0x0400, 0x0600, then 0x0800 (same index, different tags) -> third fill evicts the LRU way (0x0400 line); a following read of 0x0600 hits and a read of 0x0400 misses.
REQ-039 Write 0x1234_5678 to cached 0x0400 -> sram_write=1 with sram_wdata=0x1234_5678 until sram_ready; the line is invalidated and the next read of 0x0400 misses.
REQ-040 rst=1 during READ_MISS before sram_ready -> IDLE next cycle, ready=1, sram_read=0; the subsequent read of the same address misses.
REQ-041 Set MEM_R_EN=1 and MEM_W_EN=1 together -> WRITE path taken, sram_read stays 0.
